// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, the keypad key map and scanner FSM states.
package calc_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_EQUAL = 4'hA;
  localparam key_code_t KEY_AC    = 4'hB;
  localparam key_code_t KEY_PLUS  = 4'hC;
  localparam key_code_t KEY_MINUS = 4'hD;
  localparam key_code_t KEY_MULT  = 4'hE;
  localparam key_code_t KEY_DIV   = 4'hF;

  // Indexed [row][col]; the rows follow the physical row_n drive order.
  localparam key_code_t KEYMAP [4][4] = '{
    '{4'h1,   4'h2, 4'h3,      KEY_PLUS },
    '{4'h4,   4'h5, 4'h6,      KEY_MINUS},
    '{4'h7,   4'h8, 4'h9,      KEY_MULT },
    '{KEY_AC, 4'h0, KEY_EQUAL, KEY_DIV  }
  };

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } kp_state_t;

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad columns.
module col_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, press/release debounce, one kbEN strobe per accepted key.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       kbEN,
  output logic [3:0] pressedkey
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);

  kp_state_t     state, state_nx;
  logic [1:0]    row_idx, row_nx;
  logic [1:0]    col_lat, col_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load_key;
  logic [3:0]    col_s;

  col_sync u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_n),
    .q     (col_s)
  );

  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      row_idx <= '0;
      col_lat <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      row_idx <= row_nx;
      col_lat <= col_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row_idx;
    col_nx   = col_lat;
    cnt_nx   = cnt;
    load_key = 1'b0;
    case (state)
      SCAN: begin
        if (col_s != '1) begin
          state_nx = DEBOUNCE;
          col_nx   = lowest_low(col_s);
          cnt_nx   = '0;
        end else if (cnt == SCAN_LAST) begin
          cnt_nx = '0;
          row_nx = row_idx + 2'd1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!col_s[col_lat]) begin
          if (cnt == DEB_LAST) begin
            state_nx = EMIT;
            cnt_nx   = '0;
            load_key = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          state_nx = SCAN;
          cnt_nx   = '0;
        end
      end
      EMIT: begin
        state_nx = WAIT_RELEASE;
        cnt_nx   = '0;
      end
      WAIT_RELEASE: begin
        if (col_s == '1) begin
          if (cnt == DEB_LAST) begin
            state_nx = SCAN;
            cnt_nx   = '0;
            row_nx   = row_idx + 2'd1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          cnt_nx = '0;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  // Loaded on the edge into EMIT so the new code is already valid while kbEN is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressedkey <= '0;
    end else if (load_key) begin
      pressedkey <= KEYMAP[row_idx][col_lat];
    end
  end

  assign row_n = ~(4'b0001 << row_idx);
  assign kbEN  = (state == EMIT);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives col_n, a monitor checks strobes.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       kbEN;
  logic [3:0] pressedkey;

  logic [3:0] keys [4];
  logic [3:0] expq [$];
  logic [3:0] last_code = 4'h0;
  logic       prev_en = 1'b0;
  int         tests = 0;
  int         fails = 0;

  logic [3:0] ref_map [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hB, 4'h0, 4'hA, 4'hF}
  };

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_n      (col_n),
    .row_n      (row_n),
    .kbEN       (kbEN),
    .pressedkey (pressedkey)
  );

  always #5 clk = ~clk;

  // Switch matrix: a column reads low when a held key sits on a row driven low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r][c]) col_n[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] expect_code(input int r, input logic [3:0] m);
    for (int c = 0; c < 4; c++)
      if (m[c]) return ref_map[r][c];
    return 4'h0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_kbEN", {3'b0, kbEN}, 4'h0);
      chk("rst_row_n", row_n, 4'b1110);
      chk("rst_pressedkey", pressedkey, 4'h0);
      last_code = 4'h0;
      prev_en   = 1'b0;
    end else begin
      chk("row_onehot", 4'($countones(~row_n)), 4'd1);
      if (kbEN) begin
        chk("no_double_strobe", {3'b0, prev_en}, 4'h0);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got kbEN=1 code %h, expected no strobe at %0t", pressedkey, $time);
        end else begin
          last_code = expq.pop_front();
          chk("strobe_code", pressedkey, last_code);
        end
      end else begin
        chk("hold_code", pressedkey, last_code);
      end
      prev_en = kbEN;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int r, input logic [3:0] m, input int hold, input int rel);
    expq.push_back(expect_code(r, m));
    keys[r] = m;
    tick(hold);
    keys[r] = '0;
    tick(rel);
  endtask

  task automatic glitch(input int r, input int c, input int len);
    logic [3:0] r0;
    logic       moved;
    keys[r] = 4'b0001 << c;
    tick(len);
    keys[r] = '0;
    r0 = row_n;
    moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row_n != r0) moved = 1'b1;
    end
    chk("scan_resumes", {3'b0, moved}, 4'h1);
    tick(4);
  endtask

  initial begin
    for (int r = 0; r < 4; r++) keys[r] = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Clean press r0/c3, row stays frozen while held.
    expq.push_back(4'hC);
    keys[0] = 4'b1000;
    tick(30);
    chk("row_frozen_r0", row_n, 4'b1110);
    tick(10);
    chk("row_frozen_r0_late", row_n, 4'b1110);
    keys[0] = '0;
    tick(20);

    glitch(2, 1, 3);

    // 1, plus, 1, equal
    press(0, 4'b0001, 40, 20);
    press(0, 4'b1000, 40, 20);
    press(0, 4'b0001, 40, 20);
    press(3, 4'b0100, 40, 20);

    // Two keys in the same row: lowest column wins.
    press(1, 4'b0101, 60, 20);

    // Release bounce after r3/c1.
    expq.push_back(4'h0);
    keys[3] = 4'b0010;
    tick(40);
    for (int i = 0; i < 6; i++) begin
      keys[3] = (i % 2 == 0) ? 4'b0000 : 4'b0010;
      tick(3);
      chk("bounce_row_frozen", row_n, 4'b0111);
    end
    keys[3] = '0;
    tick(5);
    chk("bounce_still_waiting", row_n, 4'b0111);
    tick(20);

    // Reset five cycles into DEBOUNCE, key kept held through reset.
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    keys[0] = 4'b0001;
    tick(8);
    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    expq.push_back(4'h1);
    tick(40);
    keys[0] = '0;
    tick(20);

    for (int i = 0; i < 24; i++) begin
      int kind;
      int r;
      kind = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      if (kind <= 1)
        press(r, 4'b0001 << $urandom_range(0, 3), $urandom_range(35, 60), $urandom_range(15, 25));
      else if (kind == 2)
        press(r, 4'($urandom_range(1, 15)), $urandom_range(35, 60), $urandom_range(15, 25));
      else
        glitch(r, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
    chk("all_strobes_seen", 4'(expq.size()), 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each row stays driven while scanning.
REQ-002 Parameter DEBOUNCE_CYC, default 20000: consecutive stable cycles required to accept a press or a release.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 col_n  input  4  keypad columns, active-low, asynchronous to clk.
REQ-006 row_n  output  4  keypad row drive, active-low, one-hot-low.
REQ-007 kbEN  output  1  one-cycle strobe, new key accepted; feeds mainFSB kbEN.
REQ-008 pressedkey  output  4  code of last accepted key; feeds mainFSB pressedkey.

Function
REQ-009 col_n shall pass through a 2-FF synchronizer; all decisions shall use the synchronized value only.
REQ-010 FSM states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-011 SCAN: drive one row low; after SCAN_DIV cycles with all synced columns high, advance row 0->1->2->3->0 (wrap).
REQ-012 SCAN: any synced column low -> DEBOUNCE; freeze row; latch row index and the lowest-index low column.
REQ-013 DEBOUNCE: latched column stays low for DEBOUNCE_CYC consecutive cycles -> EMIT; it goes high earlier -> SCAN, same row, row counter cleared, no strobe.
REQ-014 EMIT (exactly one cycle): pressedkey <= keymap[row][col], kbEN = 1; next state WAIT_RELEASE.
REQ-015 Key map (row, col0..col3): r0 = 1,2,3,4'hC(plus); r1 = 4,5,6,4'hD(minus); r2 = 7,8,9,4'hE(mult); r3 = 4'hB(AC),0,4'hA(equal),4'hF(div).
REQ-016 pressedkey shall change only in EMIT and hold its value between strobes.
REQ-017 WAIT_RELEASE: row frozen; all synced columns high for DEBOUNCE_CYC consecutive cycles -> SCAN, next row; any low sample restarts the count.
REQ-018 Several keys down in the scanned row: lowest column index wins; exactly one strobe.
REQ-019 Keys pressed while in DEBOUNCE/EMIT/WAIT_RELEASE shall be ignored; no strobe until full release and re-detection.
REQ-020 Held key: exactly one kbEN per press; no auto-repeat.
REQ-021 kbEN shall never be high on two consecutive cycles.
REQ-022 Counter widths shall be $clog2(max(SCAN_DIV, DEBOUNCE_CYC)+1); no overflow at either parameter's maximum.

Reset
REQ-023 rst_n low: state = SCAN, row_n = 4'b1110, kbEN = 0, pressedkey = 4'h0, counters and synchronizer = idle (sync regs 4'b1111).
REQ-024 Reset asserted mid-DEBOUNCE or mid-WAIT_RELEASE: no strobe, latched key discarded.
REQ-025 After rst_n deasserts, scanning shall start on the first clk edge.

Structure
REQ-026 Key-code constants (KEY_EQUAL=4'hA, KEY_AC=4'hB, KEY_PLUS=4'hC, KEY_MINUS=4'hD, KEY_MULT=4'hE, KEY_DIV=4'hF) and the keymap table shall live in shared package calc_pkg, also used by mainFSB.
REQ-027 The 2-FF synchronizer shall be a separate sub-module col_sync (4 bits wide, reset to all-ones).

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8)
REQ-028 Model a clean press at r0/c3 for 40 cycles, then release -> one kbEN, pressedkey = 4'hC, row_n held at 4'b1110 while pressed.
REQ-029 Model a 3-cycle glitch on r2/c1 -> no kbEN, pressedkey unchanged, scanning resumes.
REQ-030 Sequence 1, plus, 1, equal (r0c0, r0c3, r0c0, r3c2), each held then released -> four strobes with codes 1, C, 1, A; mainFSB shows Display = 2.
REQ-031 Hold r1c0 and r1c2 together -> single strobe, pressedkey = 4; no second strobe until both released.
REQ-032 Release bounce (col toggling every 3 cycles) after r3c1 press -> one strobe (code 0), FSM stays in WAIT_RELEASE until 8 clean high cycles.
REQ-033 Assert rst_n low 5 cycles into DEBOUNCE -> no kbEN, outputs at reset values; key still held after reset -> one strobe after re-debounce.
